// File: rtl/mem_sdp_pipe.sv
// Simple-dual-port memory: byte-masked write port, fixed-latency read pipeline with valid/range tracking.
// Optional macro MEM_SDP_FWD_EN forwards same-cycle write data to a colliding read.
module mem_sdp_pipe #(
  parameter int MEM_DATAWIDTH = 128,
  parameter int MEM_ADDRWIDTH = 14,
  parameter int MEM_DEPTH     = 2**MEM_ADDRWIDTH,
  parameter int READ_LATENCY  = 1,
  localparam int NB           = (MEM_DATAWIDTH + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ena,
  input  logic [NB-1:0]            wea,
  input  logic [MEM_ADDRWIDTH-1:0] addra,
  input  logic [MEM_DATAWIDTH-1:0] dina,
  input  logic                     enb,
  input  logic [MEM_ADDRWIDTH-1:0] addrb,
  output logic [MEM_DATAWIDTH-1:0] doutb,
  output logic                     doutb_valid,
  output logic                     wr_err,
  output logic                     rd_err
);
  localparam int IW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int STAGES = READ_LATENCY - 1;
  localparam logic [MEM_ADDRWIDTH:0] DEPTH_W = (MEM_ADDRWIDTH+1)'(MEM_DEPTH);

  logic [MEM_DATAWIDTH-1:0] r_mem [MEM_DEPTH];

  logic [MEM_DATAWIDTH-1:0] w_mask;
  logic [MEM_DATAWIDTH-1:0] w_old;
  logic [MEM_DATAWIDTH-1:0] w_rd_data;
  logic                     w_wa_ok;
  logic                     w_ra_ok;
  logic                     w_wr_ok;
  logic [IW-1:0]            w_wa;
  logic [IW-1:0]            w_ra;

  logic [STAGES:0]                    r_vld_pipe;
  logic [STAGES:0]                    r_err_pipe;
  logic [STAGES:0][MEM_DATAWIDTH-1:0] r_dat_pipe;
  logic                               r_wr_err;

  // Bit-level write mask; a partial top lane simply covers fewer bits.
  for (genvar b = 0; b < MEM_DATAWIDTH; b++) begin : g_mask
    assign w_mask[b] = wea[b/8];
  end

  assign w_wa_ok = ({1'b0, addra} < DEPTH_W);
  assign w_ra_ok = ({1'b0, addrb} < DEPTH_W);
  assign w_wr_ok = ena && w_wa_ok;
  assign w_wa    = addra[IW-1:0];
  assign w_ra    = addrb[IW-1:0];
  assign w_old   = r_mem[w_ra];

`ifdef MEM_SDP_FWD_EN
  logic w_hit;
  assign w_hit     = w_wr_ok && enb && (addra == addrb);
  assign w_rd_data = !w_ra_ok ? '0 :
                     w_hit    ? ((w_old & ~w_mask) | (dina & w_mask)) : w_old;
`else
  // Array read happens before the edge that commits the write: old data on collision.
  assign w_rd_data = w_ra_ok ? w_old : '0;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[w_wa] <= (r_mem[w_wa] & ~w_mask) | (dina & w_mask);
  end

  // Data stages only advance behind a valid bit, so the last stage doubles as the held doutb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_err_pipe <= '0;
      r_dat_pipe <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_err      <= ena && !w_wa_ok;
      r_vld_pipe[0] <= enb;
      r_err_pipe[0] <= enb && !w_ra_ok;
      if (enb)
        r_dat_pipe[0] <= w_rd_data;
      for (int k = 1; k <= STAGES; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_err_pipe[k] <= r_err_pipe[k-1];
        if (r_vld_pipe[k-1])
          r_dat_pipe[k] <= r_dat_pipe[k-1];
      end
    end
  end

  assign doutb       = r_dat_pipe[STAGES];
  assign doutb_valid = r_vld_pipe[STAGES];
  assign rd_err      = r_err_pipe[STAGES];
  assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_mem_sdp_pipe.sv
// Directed bench for mem_sdp_pipe: four instances (READ_LATENCY 1..4) share one stimulus stream.
module tb_mem_sdp_pipe;
  localparam int W  = 36;
  localparam int AW = 10;
  localparam int NB = 5;

  localparam logic [W-1:0] ONES = 36'hF_FFFF_FFFF;
  localparam logic [W-1:0] AA   = 36'hA_AAAA_AAAA;
  localparam logic [W-1:0] FIVE = 36'h5_5555_5555;
  localparam logic [W-1:0] MIX  = 36'h0_5555_0055;
`ifdef MEM_SDP_FWD_EN
  localparam logic [W-1:0] COL8  = FIVE;
  localparam logic [W-1:0] COL10 = MIX;
`else
  localparam logic [W-1:0] COL8  = AA;
  localparam logic [W-1:0] COL10 = FIVE;
`endif

  logic          clk, reset_n, ena, enb;
  logic [NB-1:0] wea;
  logic [AW-1:0] addra, addrb;
  logic [W-1:0]  dina;
  logic [W-1:0]  doutb_a [4];
  logic          dv_a [4];
  logic          we_a [4];
  logic          re_a [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_sdp_pipe #(
      .MEM_DATAWIDTH(W), .MEM_ADDRWIDTH(AW), .MEM_DEPTH(1000), .READ_LATENCY(g+1)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .enb(enb), .addrb(addrb), .doutb(doutb_a[g]), .doutb_valid(dv_a[g]),
      .wr_err(we_a[g]), .rd_err(re_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ena;
    logic [NB-1:0] wea;
    logic [AW-1:0] addra;
    logic [W-1:0]  dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [W-1:0]  e_dout;
    logic          e_vld;
    logic          e_wr;
    logic          e_rd;
  } vec_t;

  vec_t tbl [17];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] val(input int i);
    return 36'h9_0000_0000 | (36'(i) * 36'h0_0101_0101);
  endfunction

  task automatic chk_all_zero(input string tag);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s L%0d doutb", tag, l+1), doutb_a[l], '0);
      chk($sformatf("%s L%0d valid", tag, l+1), W'(dv_a[l]), '0);
      chk($sformatf("%s L%0d wr_err", tag, l+1), W'(we_a[l]), '0);
      chk($sformatf("%s L%0d rd_err", tag, l+1), W'(re_a[l]), '0);
    end
  endtask

  initial begin
    int k;
    //           ena  wea     addra    dina            enb  addrb     e_dout          v     wr    rd
    tbl[0]  = '{1'b1, 5'h1F, 10'd5,    36'h0,          1'b0, 10'd0,    36'h0,          1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'h01, 10'd5,    ONES,           1'b0, 10'd0,    36'h0,          1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 5'h00, 10'd0,    36'h0,          1'b1, 10'd5,    36'h0_0000_00FF, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'h1F, 10'd0,    36'h1_2345_6789, 1'b0, 10'd0,   36'h0_0000_00FF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5'h1F, 10'd1000, 36'hF_0000_0000, 1'b0, 10'd0,   36'h0_0000_00FF, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 5'h00, 10'd0,    36'h0,          1'b1, 10'd0,    36'h1_2345_6789, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'h00, 10'd0,    36'h0,          1'b1, 10'd1023, 36'h0,          1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 5'h1F, 10'd7,    AA,             1'b0, 10'd0,    36'h0,          1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'h1F, 10'd7,    FIVE,           1'b1, 10'd7,    COL8,           1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'h00, 10'd0,    36'h0,          1'b1, 10'd7,    FIVE,           1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'h12, 10'd7,    36'h0,          1'b1, 10'd7,    COL10,          1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 5'h00, 10'd0,    36'h0,          1'b1, 10'd7,    MIX,            1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 5'h00, 10'd7,    36'h0,          1'b1, 10'd7,    MIX,            1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'h00, 10'd0,    36'h0,          1'b0, 10'd0,    MIX,            1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 5'h1F, 10'd999,  36'h3_3333_3333, 1'b0, 10'd0,   MIX,            1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 5'h00, 10'd0,    36'h0,          1'b1, 10'd999,  36'h3_3333_3333, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 5'h1F, 10'd1000, 36'h0,          1'b1, 10'd1000, 36'h0,          1'b1, 1'b1, 1'b1};

    reset_n = 1'b0; ena = 1'b0; enb = 1'b0; wea = '0; addra = '0; addrb = '0; dina = '0;
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Table: each row applied at a negedge, latency-1 outputs checked at the next.
    for (int i = 0; i < 17; i++) begin
      ena = tbl[i].ena; wea = tbl[i].wea; addra = tbl[i].addra; dina = tbl[i].dina;
      enb = tbl[i].enb; addrb = tbl[i].addrb;
      @(negedge clk);
      chk($sformatf("row%0d doutb", i), doutb_a[0], tbl[i].e_dout);
      chk($sformatf("row%0d valid", i), W'(dv_a[0]), W'(tbl[i].e_vld));
      chk($sformatf("row%0d wr_err", i), W'(we_a[0]), W'(tbl[i].e_wr));
      chk($sformatf("row%0d rd_err", i), W'(re_a[0]), W'(tbl[i].e_rd));
    end

    // Preload 16 distinct words, then sweep back-to-back reads through all latencies.
    enb = 1'b0; ena = 1'b1; wea = 5'h1F;
    for (int i = 0; i < 16; i++) begin
      addra = AW'(100 + i); dina = val(i);
      @(negedge clk);
    end
    ena = 1'b0;
    @(negedge clk);
    enb = 1'b1; addrb = AW'(100);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      for (int l = 1; l <= 4; l++) begin
        k = c - l;
        chk($sformatf("sweep c%0d L%0d valid", c, l), W'(dv_a[l-1]), W'(k >= 0 && k < 16));
        if (k >= 0)
          chk($sformatf("sweep c%0d L%0d doutb", c, l), doutb_a[l-1], val(k < 16 ? k : 15));
      end
      if (c < 16) addrb = AW'(100 + c);
      else        enb = 1'b0;
    end

    // Reset in the middle of a burst: in-flight reads must vanish.
    @(negedge clk);
    enb = 1'b1; addrb = AW'(100);
    @(negedge clk);
    addrb = AW'(101);
    @(negedge clk);
    enb = 1'b0; reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int l = 0; l < 4; l++)
        chk($sformatf("postreset c%0d L%0d valid", c, l+1), W'(dv_a[l]), '0);
    end
    enb = 1'b1; addrb = AW'(102);
    @(negedge clk);
    enb = 1'b0;
    @(negedge clk);
    chk("postreset L3 early valid", W'(dv_a[2]), '0);
    @(negedge clk);
    chk("postreset L3 valid", W'(dv_a[2]), W'(1'b1));
    chk("postreset L3 doutb", doutb_a[2], val(2));
    chk("postreset L3 rd_err", W'(re_a[2]), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
